// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time program writer for the pipelined processor. A byte stream
// arrives over a valid/ready handshake and is packed into little-endian
// 32-bit words. The stream carries a header word N (the payload word count),
// N payload words and a trailing checksum word. The checksum is the 32-bit
// wrapping sum of the payload words.
//
// Each payload word is written into the instruction-memory write port. The
// core is held stalled until a load has been verified, and then released.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      synchronous active-low reset
//   start        one-cycle pulse that begins a load (ignored while busy)
//   in_data      stream byte
//   in_valid     in_data is valid
//   in_ready     loader accepts a byte this cycle
//   mem_we       instruction-memory write enable, one cycle per word
//   mem_addr     word address of the write (holds when mem_we=0)
//   mem_wdata    word written (holds when mem_we=0)
//   core_run     1 = core may execute, 0 = core held stalled
//   busy         load in progress
//   done         last load verified
//   error        last load failed (bad header or bad checksum)
//   words_loaded payload words written in the current or last load
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_run,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CSUM,
    DONE,
    ERROR
  } state_t;

  localparam logic [31:0] DepthWord = 32'(DEPTH);

  state_t                state_q,     state_d;
  logic [1:0]            laneCnt_q,   laneCnt_d;
  logic [23:0]           assembly_q,  assembly_d;
  logic [ADDR_WIDTH:0]   hdrCount_q,  hdrCount_d;
  logic [31:0]           checksum_q,  checksum_d;
  logic [ADDR_WIDTH:0]   loaded_q,    loaded_d;
  logic                  memWe_q,     memWe_d;
  logic [ADDR_WIDTH-1:0] memAddr_q,   memAddr_d;
  logic [31:0]           memWdata_q,  memWdata_d;

  logic                  streamPhase;
  logic                  xfer;
  logic                  wordDone;
  logic [31:0]           word;
  logic [ADDR_WIDTH:0]   loadedNext;

  // The loader only listens to the stream while a load is in progress.
  assign streamPhase = (state_q == HDR) || (state_q == LOAD) || (state_q == CSUM);
  assign xfer        = in_valid && streamPhase;

  // The first three bytes of a word are shifted in from the top of the
  // assembly register, so once three have arrived it holds {b2,b1,b0} and
  // the fourth byte on the bus completes the word without another cycle.
  assign word        = {in_data, assembly_q};
  assign wordDone    = xfer && (laneCnt_q == 2'd3);
  assign loadedNext  = loaded_q + 1'b1;

  // Status outputs are pure functions of the state, which makes done and
  // error mutually exclusive by construction and lets a single start edge
  // clear them together with core_run.
  assign in_ready     = streamPhase;
  assign busy         = streamPhase;
  assign done         = (state_q == DONE);
  assign core_run     = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign mem_we       = memWe_q;
  assign mem_addr     = memAddr_q;
  assign mem_wdata    = memWdata_q;
  assign words_loaded = loaded_q;

  // Next-state and datapath logic. Every register holds by default; the
  // write strobe defaults low so it lasts exactly one cycle per word.
  always_comb begin
    state_d    = state_q;
    laneCnt_d  = laneCnt_q;
    assembly_d = assembly_q;
    hdrCount_d = hdrCount_q;
    checksum_d = checksum_q;
    loaded_d   = loaded_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;

    if (xfer) begin
      laneCnt_d  = laneCnt_q + 2'd1;
      assembly_d = {in_data, assembly_q[23:8]};
    end

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d    = HDR;
          laneCnt_d  = 2'd0;
          checksum_d = 32'd0;
          loaded_d   = '0;
        end
      end

      HDR: begin
        if (wordDone) begin
          if ((word == 32'd0) || (word > DepthWord)) begin
            state_d = ERROR;
          end else begin
            hdrCount_d = word[ADDR_WIDTH:0];
            state_d    = LOAD;
          end
        end
      end

      // The address of each write is the count of words already written,
      // so the write index and words_loaded can never drift apart.
      LOAD: begin
        if (wordDone) begin
          memWe_d    = 1'b1;
          memAddr_d  = loaded_q[ADDR_WIDTH-1:0];
          memWdata_d = word;
          loaded_d   = loadedNext;
          checksum_d = checksum_q + word;
          if (loadedNext == hdrCount_q) begin
            state_d = CSUM;
          end
        end
      end

      CSUM: begin
        if (wordDone) begin
          state_d = (word == checksum_q) ? DONE : ERROR;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any load in progress; the
  // instruction memory itself lives outside and keeps whatever was written.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      laneCnt_q  <= 2'd0;
      assembly_q <= 24'd0;
      hdrCount_q <= '0;
      checksum_q <= 32'd0;
      loaded_q   <= '0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      laneCnt_q  <= laneCnt_d;
      assembly_q <= assembly_d;
      hdrCount_q <= hdrCount_d;
      checksum_q <= checksum_d;
      loaded_q   <= loaded_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

endmodule
